// File: rtl/mux_n_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mux_n_pipe
// Description : Registered N-channel, W-bit valid/ready multiplexer with either
//               external select (MODE=0) or round-robin arbitration (MODE=1).
//               Define MUX_SEL_ERR_EN to add the sticky sel_err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_n_pipe #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int MODE = 0,
  localparam int SW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [SW-1:0]   sel,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready
`ifdef MUX_SEL_ERR_EN
  ,
  output logic            sel_err
`endif
);

  logic          w_load_en;
  logic          w_grant;
  logic          w_xfer;
  logic [SW-1:0] w_grant_ch;
  logic [W-1:0]  w_grant_data;

  assign w_load_en = !out_valid || out_ready;
  assign w_xfer    = w_load_en && w_grant;

  generate
    if (MODE == 0) begin : g_ext_sel
      // An out-of-range sel matches no channel and therefore yields no grant.
      always_comb begin
        w_grant = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (sel == SW'(k) && in_valid[k]) w_grant = 1'b1;
        end
      end
      assign w_grant_ch = sel;
    end else begin : g_rr
      logic [SW-1:0] r_ptr;
      logic          w_unused_sel;

      assign w_unused_sel = ^sel;

      // Channels at or above r_ptr win over the wrapped-around ones below it;
      // descending scans leave the lowest index of each region as the winner.
      always_comb begin
        w_grant    = 1'b0;
        w_grant_ch = '0;
        for (int k = N - 1; k >= 0; k--) begin
          if (in_valid[k] && (SW'(k) < r_ptr)) begin
            w_grant    = 1'b1;
            w_grant_ch = SW'(k);
          end
        end
        for (int k = N - 1; k >= 0; k--) begin
          if (in_valid[k] && (SW'(k) >= r_ptr)) begin
            w_grant    = 1'b1;
            w_grant_ch = SW'(k);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ptr <= '0;
        end else if (w_xfer) begin
          r_ptr <= (w_grant_ch == SW'(N - 1)) ? '0 : w_grant_ch + 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    w_grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (w_grant_ch == SW'(k)) w_grant_data = in_data[k*W +: W];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < N; k++) begin
      in_ready[k] = w_xfer && !rst && (w_grant_ch == SW'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (w_load_en) begin
      out_valid <= w_grant;
      if (w_grant) begin
        out_data <= w_grant_data;
        out_ch   <= w_grant_ch;
      end
    end
  end

`ifdef MUX_SEL_ERR_EN
  logic w_sel_oor;

  always_comb begin
    w_sel_oor = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) w_sel_oor = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if ((MODE == 0) && w_load_en && w_sel_oor) begin
      sel_err <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_n_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_n_pipe
// Description : Self-checking bench for mux_n_pipe: external select (N=4),
//               round-robin (N=4) and external select (N=3) instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_n_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance 0: N=4 MODE=0
  logic        rst0 = 1'b1;
  logic [31:0] data0 = '0;
  logic [3:0]  valid0 = '0, rdy0;
  logic [1:0]  sel0 = '0, ch0;
  logic [7:0]  od0;
  logic        ov0, ordy0 = 1'b1;
  // Instance 1: N=4 MODE=1
  logic        rst1 = 1'b1;
  logic [31:0] data1 = '0;
  logic [3:0]  valid1 = '0, rdy1;
  logic [1:0]  sel1 = '0, ch1;
  logic [7:0]  od1;
  logic        ov1, ordy1 = 1'b1;
  // Instance 2: N=3 MODE=0
  logic        rst2 = 1'b1;
  logic [23:0] data2 = '0;
  logic [2:0]  valid2 = '0, rdy2;
  logic [1:0]  sel2 = '0, ch2;
  logic [7:0]  od2;
  logic        ov2, ordy2 = 1'b1;
  logic        err0, err1, err2;

  mux_n_pipe #(.W(8), .N(4), .MODE(0)) u0 (
    .clk(clk), .rst(rst0), .in_data(data0), .in_valid(valid0), .in_ready(rdy0),
    .sel(sel0), .out_data(od0), .out_ch(ch0), .out_valid(ov0), .out_ready(ordy0)
`ifdef MUX_SEL_ERR_EN
    , .sel_err(err0)
`endif
  );
  mux_n_pipe #(.W(8), .N(4), .MODE(1)) u1 (
    .clk(clk), .rst(rst1), .in_data(data1), .in_valid(valid1), .in_ready(rdy1),
    .sel(sel1), .out_data(od1), .out_ch(ch1), .out_valid(ov1), .out_ready(ordy1)
`ifdef MUX_SEL_ERR_EN
    , .sel_err(err1)
`endif
  );
  mux_n_pipe #(.W(8), .N(3), .MODE(0)) u2 (
    .clk(clk), .rst(rst2), .in_data(data2), .in_valid(valid2), .in_ready(rdy2),
    .sel(sel2), .out_data(od2), .out_ch(ch2), .out_valid(ov2), .out_ready(ordy2)
`ifdef MUX_SEL_ERR_EN
    , .sel_err(err2)
`endif
  );

`ifndef MUX_SEL_ERR_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
  assign err2 = 1'b0;
`endif

  task automatic chk(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // Reference model state, one slot per instance.
  bit m_init[3];
  bit m_v[3];
  int m_d[3];
  int m_ch[3];
  int m_ptr[3];
  bit m_err[3];

  task automatic step(input int i, input int n, input int mode, input logic r,
                      input logic [127:0] d, input logic [15:0] v, input int s,
                      input logic ordy, input logic [15:0] dut_rdy, input logic dut_ov,
                      input int dut_od, input int dut_ch, input logic dut_err);
    bit load;
    int g;
    int exp_rdy;
    load = !m_v[i] || ordy;
    g = -1;
    if (mode == 0) begin
      if (s < n && v[s]) g = s;
    end else begin
      for (int o = 0; o < n; o++) begin
        int k;
        k = (m_ptr[i] + o) % n;
        if (g < 0 && v[k]) g = k;
      end
    end
    exp_rdy = (!r && load && g >= 0) ? (1 << g) : 0;
    if (m_init[i]) begin
      chk($sformatf("u%0d out_valid", i), int'(dut_ov), int'(m_v[i]));
      chk($sformatf("u%0d out_data", i), dut_od, m_d[i]);
      chk($sformatf("u%0d out_ch", i), dut_ch, m_ch[i]);
      chk($sformatf("u%0d in_ready", i), int'(dut_rdy), exp_rdy);
`ifdef MUX_SEL_ERR_EN
      chk($sformatf("u%0d sel_err", i), int'(dut_err), int'(m_err[i]));
`endif
    end
    if (r) begin
      m_init[i] = 1'b1;
      m_v[i] = 1'b0; m_d[i] = 0; m_ch[i] = 0; m_ptr[i] = 0; m_err[i] = 1'b0;
    end else begin
      if (mode == 0 && load && s >= n) m_err[i] = 1'b1;
      if (load) begin
        if (g >= 0) begin
          m_v[i] = 1'b1;
          m_d[i] = int'(d[g*8 +: 8]);
          m_ch[i] = g;
          m_ptr[i] = (g + 1) % n;
        end else begin
          m_v[i] = 1'b0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    step(0, 4, 0, rst0, {96'b0, data0}, {12'b0, valid0}, int'(sel0), ordy0,
         {12'b0, rdy0}, ov0, int'(od0), int'(ch0), err0);
    step(1, 4, 1, rst1, {96'b0, data1}, {12'b0, valid1}, int'(sel1), ordy1,
         {12'b0, rdy1}, ov1, int'(od1), int'(ch1), err1);
    step(2, 3, 0, rst2, {104'b0, data2}, {13'b0, valid2}, int'(sel2), ordy2,
         {13'b0, rdy2}, ov2, int'(od2), int'(ch2), err2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_ch[6];
    exp_ch = '{0, 1, 2, 3, 0, 1};

    // Reset with every channel valid: nothing may be granted.
    valid0 = 4'b1111; sel0 = 2'd2; data0 = {8'h44, 8'hA5, 8'h22, 8'h11};
    tick();
    chk("t1 in_ready in reset", int'(rdy0), 0);
    tick();
    chk("t1 out_valid", int'(ov0), 0);
    chk("t1 out_data", int'(od0), 8'h00);
    chk("t1 in_ready", int'(rdy0), 0);

    // External select of channel 2.
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    valid0 = 4'b0100;
    #1 chk("t2 in_ready", int'(rdy0), 4'b0100);
    tick();
    chk("t2 out_valid", int'(ov0), 1);
    chk("t2 out_data", int'(od0), 8'hA5);
    chk("t2 out_ch", int'(od0 == 8'hA5 ? ch0 : 2'd0), 2);
    valid0 = 4'b0001; sel0 = 2'd0;
    tick();
    chk("t3 hold word", int'(od0), 8'h11);

    // Back-pressure: stalled output ignores sel/data changes.
    ordy0 = 1'b0; valid0 = 4'b1000; sel0 = 2'd3;
    #1 chk("t3 in_ready stalled", int'(rdy0), 0);
    tick();
    tick();
    chk("t3 stalled data", int'(od0), 8'h11);
    chk("t3 stalled valid", int'(ov0), 1);
    ordy0 = 1'b1;
    #1 chk("t3 in_ready resume", int'(rdy0), 4'b1000);
    tick();
    chk("t3 no bubble data", int'(od0), 8'h44);
    chk("t3 no bubble ch", int'(ch0), 3);
    valid0 = 4'b0000;
    tick();
    chk("t3 drained", int'(ov0), 0);

    // Reset while holding a stalled word drops it.
    valid0 = 4'b0010; sel0 = 2'd1;
    tick();
    valid0 = 4'b0000; ordy0 = 1'b0;
    tick();
    chk("rst-mid held", int'(ov0), 1);
    rst0 = 1'b1;
    tick();
    chk("rst-mid dropped", int'(ov0), 0);
    rst0 = 1'b0; ordy0 = 1'b1;

    // Round robin with all channels valid.
    data1 = {8'h13, 8'h12, 8'h11, 8'h10}; valid1 = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk($sformatf("t4 rr ch[%0d]", t), int'(ch1), exp_ch[t]);
      chk($sformatf("t4 rr data[%0d]", t), int'(od1), 8'h10 + exp_ch[t]);
    end
    tick();
    chk("t5 pre ch", int'(ch1), 2);
    // Pointer now 3; only channels 0 and 1 requesting.
    valid1 = 4'b0011;
    tick();
    chk("t5 wrap grant", int'(ch1), 0);
    tick();
    chk("t5 next grant", int'(ch1), 1);
    ordy1 = 1'b0;
    tick();
    tick();
    chk("t5 rr stalled", int'(ch1), 1);
    ordy1 = 1'b1;
    tick();
    chk("t5 rr resumed", int'(ch1), 0);
    valid1 = 4'b0000;
    tick();
    chk("t5 rr idle", int'(ov1), 0);

    // N=3 with an out-of-range select.
    data2 = {8'h33, 8'h22, 8'h11}; valid2 = 3'b111; sel2 = 2'd0;
    tick();
    chk("t6 load ch0", int'(od2), 8'h11);
    sel2 = 2'd3;
    #1 chk("t6 in_ready oor", int'(rdy2), 0);
    tick();
    chk("t6 out_valid falls", int'(ov2), 0);
    chk("t6 data holds", int'(od2), 8'h11);
`ifdef MUX_SEL_ERR_EN
    chk("t6 sel_err set", int'(err2), 1);
`endif
    sel2 = 2'd2;
    tick();
    chk("t6 recover data", int'(od2), 8'h33);
`ifdef MUX_SEL_ERR_EN
    chk("t6 sel_err sticky", int'(err2), 1);
`endif
    rst2 = 1'b1;
    tick();
    chk("t6 reset valid", int'(ov2), 0);
`ifdef MUX_SEL_ERR_EN
    chk("t6 sel_err cleared", int'(err2), 0);
`endif
    rst2 = 1'b0; valid2 = 3'b000;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
